// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one outstanding access,
// fixed LATENCY, byte-lane masking on stores and aligned, extended loads.
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [31:0]           req_addr_i,
    input  logic                  req_we_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [1:0]            req_type_i,
    input  logic                  req_sign_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);
    localparam int         WORDS    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [1:0]              type_q;
    logic                    sign_q;
    logic [DATA_WIDTH-1:0]   mem [WORDS];

    logic                    accept;
    logic                    do_access;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    sel_we;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [1:0]              sel_type;
    logic                    sel_sign;
    logic [ADDR_WIDTH-3:0]   widx;
    logic                    acc_err;
    logic [3:0]              be;
    logic [DATA_WIDTH-1:0]   wlanes;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   result;
    logic                    unused_addr;

    function automatic logic access_err(input logic [1:0] typ, input logic [1:0] lo);
        case (typ)
            2'b00:   access_err = 1'b0;
            2'b01:   access_err = lo[0];
            2'b10:   access_err = (lo != 2'b00);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] typ, input logic [1:0] lo);
        case (typ)
            2'b00:   byte_en = 4'b0001 << lo;
            2'b01:   byte_en = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] typ, input logic [31:0] w);
        case (typ)
            2'b00:   store_lanes = {4{w[7:0]}};
            2'b01:   store_lanes = {2{w[15:0]}};
            default: store_lanes = w;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] typ, input logic sgn,
                                                 input logic [1:0] lo, input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (typ)
            2'b00:   load_extract = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   load_extract = {{16{sgn & sh[15]}}, sh[15:0]};
            default: load_extract = word;
        endcase
    endfunction

    // Upper address bits are deliberately ignored so the address space wraps.
    assign unused_addr = ^req_addr_i[31:ADDR_WIDTH];

    // With LATENCY==1 the access uses the live request on its accept edge.
    assign accept    = (state == IDLE) && req_valid_i && req_ready_o;
    assign do_access = (accept && (LATENCY == 1)) || ((state == BUSY) && (cnt == 4'd0));

    assign sel_addr  = (state == IDLE) ? req_addr_i[ADDR_WIDTH-1:0] : addr_q;
    assign sel_we    = (state == IDLE) ? req_we_i    : we_q;
    assign sel_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
    assign sel_type  = (state == IDLE) ? req_type_i  : type_q;
    assign sel_sign  = (state == IDLE) ? req_sign_i  : sign_q;

    assign widx    = sel_addr[ADDR_WIDTH-1:2];
    assign acc_err = access_err(sel_type, sel_addr[1:0]);
    assign be      = byte_en(sel_type, sel_addr[1:0]);
    assign wlanes  = store_lanes(sel_type, sel_wdata);
    assign rd_word = mem[widx];
    assign result  = (sel_we || acc_err) ? '0 : load_extract(sel_type, sel_sign, sel_addr[1:0], rd_word);

    // Memory has no reset; a reset edge simply blocks the commit.
    always_ff @(posedge clk) begin
        if (rst && do_access && sel_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q      <= req_addr_i[ADDR_WIDTH-1:0];
                        we_q        <= req_we_i;
                        wdata_q     <= req_wdata_i;
                        type_q      <= req_type_i;
                        sign_q      <= req_sign_i;
                        req_ready_o <= 1'b0;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_rdata_o <= result;
                            rsp_err_o   <= acc_err;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= result;
                        rsp_err_o   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    rsp_valid_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances at LATENCY 2, 1 and 4.
module tb_dmem_responder;
    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] req_addr  [3];
    logic [2:0]  req_we;
    logic [31:0] req_wdata [3];
    logic [1:0]  req_type  [3];
    logic [2:0]  req_sign;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_rdata [3];
    logic [2:0]  rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(L)) dut (
            .clk         (clk),
            .rst         (rst),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .req_we_i    (req_we[g]),
            .req_wdata_i (req_wdata[g]),
            .req_type_i  (req_type[g]),
            .req_sign_i  (req_sign[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction; hold>0 stalls the response for that many cycles.
    task automatic do_req(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] typ, input logic sgn,
                          input logic [31:0] exp_d, input logic exp_e, input int hold);
        int n;
        int edges;
        exp_t e;
        logic stable;
        logic [31:0] held;
        @(negedge clk);
        rsp_ready[k] = (hold == 0);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_type[k]  = typ;
        req_sign[k]  = sgn;
        e.rdata = exp_d;
        e.err   = exp_e;
        sb.push_back(e);
        n = 0;
        while (!req_ready[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'(n), 0);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = ~we;
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        req_type[k]  = 2'($urandom_range(0, 3));
        req_sign[k]  = ~sgn;
        edges = 1;
        while (!rsp_valid[k] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 32'(edges), 32'(lat_of(k)));
        if (sb.size() == 0) begin
            check("sb_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check("rdata", rsp_rdata[k], e.rdata);
            check("err", 32'(rsp_err[k]), 32'(e.err));
        end
        if (hold > 0) begin
            stable = 1'b1;
            held   = rsp_rdata[k];
            repeat (hold) begin
                @(posedge clk);
                #1;
                if (!rsp_valid[k] || rsp_rdata[k] !== held || req_ready[k]) stable = 1'b0;
            end
            check("stall_stable", 32'(stable), 1);
            @(negedge clk);
            rsp_ready[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("hs_valid_low", 32'(rsp_valid[k]), 0);
        check("hs_ready_high", 32'(req_ready[k]), 1);
    endtask

    // Store word that is hit by reset before it can commit.
    task automatic abort_store(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        logic quiet;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b1;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_type[k]  = 2'b10;
        req_sign[k]  = 1'b0;
        check("abort_ready_pre", 32'(req_ready[k]), 1);
        if (lat_of(k) == 1) rst = 1'b0;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        if (lat_of(k) != 1) begin
            rst = 1'b0;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid[k]) quiet = 1'b0;
        end
        check("abort_no_rsp", 32'(quiet), 1);
        check("abort_ready_post", 32'(req_ready[k]), 1);
    endtask

    initial begin
        logic [7:0] bv [4];
        bv[0] = 8'h7F; bv[1] = 8'h80; bv[2] = 8'h01; bv[3] = 8'hFE;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
            req_type[k] = 2'b00; req_sign[k] = 1'b0; rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", 32'(rsp_valid[k]), 0);
            check("rst_rdata", rsp_rdata[k], 0);
            check("rst_err", 32'(rsp_err[k]), 0);
            check("rst_ready", 32'(req_ready[k]), 1);
        end
        @(negedge clk);
        rst = 1'b1;

        do_req(0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 0);
        do_req(0, 1'b1, 32'h103, 32'hFFFFFFAB, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        do_req(0, 1'b1, 32'h100, 32'hCCCC1234, 2'b01, 1'b0, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hABAD1234, 1'b0, 0);
        do_req(0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b1, 32'hFFFFFFAB, 1'b0, 0);
        do_req(0, 1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 32'h000000AB, 1'b0, 0);
        do_req(0, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 32'hFFFFABAD, 1'b0, 0);
        do_req(0, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h101, 32'h0, 2'b01, 1'b0, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'h100, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'h102, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b1, 32'hABAD1234, 1'b0, 0);
        do_req(0, 1'b0, 32'hFFFE0100, 32'h0, 2'b10, 1'b0, 32'hABAD1234, 1'b0, 0);
        do_req(0, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 32'hABAD1234, 1'b0, 5);

        for (int i = 0; i < 4; i++)
            do_req(0, 1'b1, 32'h300 + 32'(i), {24'h5A5A5A, bv[i]}, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        for (int i = 0; i < 4; i++)
            do_req(0, 1'b0, 32'h300 + 32'(i), 32'h0, 2'b00, 1'b1,
                   {{24{bv[i][7]}}, bv[i]}, 1'b0, 0);
        do_req(0, 1'b0, 32'h300, 32'h0, 2'b01, 1'b1, {16'hFFFF, bv[1], bv[0]}, 1'b0, 0);
        do_req(0, 1'b0, 32'h302, 32'h0, 2'b01, 1'b0, {16'h0000, bv[3], bv[2]}, 1'b0, 0);

        for (int k = 1; k < 3; k++) begin
            do_req(k, 1'b1, 32'h200, 32'h0BADF00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
            abort_store(k, 32'h200, 32'h55555555);
            do_req(k, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, 0);
        end
        do_req(2, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 32'h0BADF00D, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
